// File: rtl/pipe_stage_skid.sv
// Reusable pipeline stage register with a two-entry skid buffer, synchronous
// flush and a saturating stall counter. Bubbles always carry an all-zero control field.
module pipe_stage_skid #(
  parameter int CTRL_W   = 11,
  parameter int DATA_W   = 175,
  parameter int CLR_DATA = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a beat moves on an edge where valid and ready are both high on
  // that side; valid never waits on ready, and ready_o is a flop (never combinational
  // from ready_i), so the stage breaks the backpressure timing path.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state;
  logic                validQ;
  logic                readyQ;
  logic [1:0]          occQ;
  logic [CTRL_W-1:0]   mainCtrl;
  logic [DATA_W-1:0]   mainData;
  logic [CTRL_W-1:0]   skidCtrl;
  logic [DATA_W-1:0]   skidData;
  logic [CNT_W-1:0]    stallQ;

  logic accept;
  logic take;

  assign accept = valid_i & readyQ;
  assign take   = validQ & ready_i;

  assign ready_o   = readyQ;
  assign valid_o   = validQ;
  assign ctrl_o    = mainCtrl;
  assign data_o    = mainData;
  assign occupancy = occQ;
  assign stall_cnt = stallQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      validQ   <= 1'b0;
      readyQ   <= 1'b1;
      occQ     <= 2'd0;
      mainCtrl <= '0;
      mainData <= '0;
      skidCtrl <= '0;
      skidData <= '0;
      stallQ   <= '0;
    end else begin
      // Sampled before the edge, so a flush cycle that was stalled still counts.
      if (validQ && !ready_i && stallQ != CNT_MAX)
        stallQ <= stallQ + CNT_W'(1);

      if (flush) begin
        state    <= EMPTY;
        validQ   <= 1'b0;
        readyQ   <= 1'b1;
        occQ     <= 2'd0;
        mainCtrl <= '0;
        skidCtrl <= '0;
        if (CLR_DATA != 0) begin
          mainData <= '0;
          skidData <= '0;
        end
      end else begin
        unique case (state)
          EMPTY: begin
            if (accept) begin
              mainCtrl <= ctrl_i;
              mainData <= data_i;
              state    <= ONE;
              validQ   <= 1'b1;
              readyQ   <= 1'b1;
              occQ     <= 2'd1;
            end
          end
          ONE: begin
            if (accept && take) begin
              mainCtrl <= ctrl_i;
              mainData <= data_i;
            end else if (accept) begin
              skidCtrl <= ctrl_i;
              skidData <= data_i;
              state    <= FULL;
              readyQ   <= 1'b0;
              occQ     <= 2'd2;
            end else if (take) begin
              mainCtrl <= '0;
              if (CLR_DATA != 0)
                mainData <= '0;
              state    <= EMPTY;
              validQ   <= 1'b0;
              occQ     <= 2'd0;
            end
          end
          FULL: begin
            // ready_o is low here, so only a take can happen.
            if (take) begin
              mainCtrl <= skidCtrl;
              mainData <= skidData;
              skidCtrl <= '0;
              state    <= ONE;
              readyQ   <= 1'b1;
              occQ     <= 2'd1;
            end
          end
          default: begin
            state    <= EMPTY;
            validQ   <= 1'b0;
            readyQ   <= 1'b1;
            occQ     <= 2'd0;
            mainCtrl <= '0;
            skidCtrl <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: three instances share stimulus
// (CLR_DATA=0, CLR_DATA=1, CNT_W=4) and are compared against hand-computed values.
module tb_pipe_stage_skid;

  localparam int CTRL_W = 11;
  localparam int DATA_W = 175;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              valid_i = 1'b0;
  logic              ready_i = 1'b0;
  logic [CTRL_W-1:0] ctrl_i = '0;
  logic [DATA_W-1:0] data_i = '0;

  logic              ready_a, valid_a, ready_b, valid_b, ready_c, valid_c;
  logic [CTRL_W-1:0] ctrl_a, ctrl_b, ctrl_c;
  logic [DATA_W-1:0] data_a, data_b, data_c;
  logic [1:0]        occ_a, occ_b, occ_c;
  logic [15:0]       stall_a, stall_b;
  logic [3:0]        stall_c;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CLR_DATA(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_i(valid_i), .ready_o(ready_a),
    .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(valid_a), .ready_i(ready_i),
    .ctrl_o(ctrl_a), .data_o(data_a), .occupancy(occ_a), .stall_cnt(stall_a)
  );

  pipe_stage_skid #(.CLR_DATA(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_i(valid_i), .ready_o(ready_b),
    .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(valid_b), .ready_i(ready_i),
    .ctrl_o(ctrl_b), .data_o(data_b), .occupancy(occ_b), .stall_cnt(stall_b)
  );

  pipe_stage_skid #(.CLR_DATA(0), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_i(valid_i), .ready_o(ready_c),
    .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(valid_c), .ready_i(ready_i),
    .ctrl_o(ctrl_c), .data_o(data_c), .occupancy(occ_c), .stall_cnt(stall_c)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it, where outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic r, input logic f);
    valid_i = v;
    ctrl_i  = c;
    data_i  = d;
    ready_i = r;
    flush   = f;
  endtask

  task automatic check_main(input string tag, input logic v, input logic [CTRL_W-1:0] c,
                            input logic [DATA_W-1:0] d, input logic [1:0] occ, input logic rdy);
    check({tag, ".valid"}, 256'(valid_a), 256'(v));
    check({tag, ".ctrl"},  256'(ctrl_a),  256'(c));
    check({tag, ".data"},  256'(data_a),  256'(d));
    check({tag, ".occ"},   256'(occ_a),   256'(occ));
    check({tag, ".ready"}, 256'(ready_a), 256'(rdy));
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_main("reset", 1'b0, '0, '0, 2'd0, 1'b1);
    check("reset.stall", 256'(stall_a), 256'd0);
    rst_n = 1'b1;

    // Streaming: one beat per cycle, visible one edge after accept
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 11'h7FF, DATA_W'(i), 1'b1, 1'b0);
      step();
      check_main($sformatf("stream%0d", i), 1'b1, 11'h7FF, DATA_W'(i), 2'd1, 1'b1);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    check_main("stream_end", 1'b0, '0, DATA_W'(8), 2'd0, 1'b1);
    check("stream_end.data_clr", 256'(data_b), 256'd0);
    check("stream_end.stall", 256'(stall_a), 256'd0);

    // Backpressure: A to main, B to skid, then hold
    drive(1'b1, 11'h011, DATA_W'('hA), 1'b0, 1'b0);
    step();
    check_main("bp_a", 1'b1, 11'h011, DATA_W'('hA), 2'd1, 1'b1);
    drive(1'b1, 11'h022, DATA_W'('hB), 1'b0, 1'b0);
    step();
    check_main("bp_b", 1'b1, 11'h011, DATA_W'('hA), 2'd2, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    step();
    check_main("bp_hold", 1'b1, 11'h011, DATA_W'('hA), 2'd2, 1'b0);
    check("bp_hold.stall", 256'(stall_a), 256'd3);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    check_main("bp_rel_b", 1'b1, 11'h022, DATA_W'('hB), 2'd1, 1'b1);
    check("bp_rel.stall", 256'(stall_a), 256'd3);
    step();
    check_main("bp_empty", 1'b0, '0, DATA_W'('hB), 2'd0, 1'b1);

    // Flush in FULL with beat C offered
    drive(1'b1, 11'h033, DATA_W'('h21), 1'b0, 1'b0);
    step();
    drive(1'b1, 11'h044, DATA_W'('h22), 1'b0, 1'b0);
    step();
    check("fl_full.occ", 256'(occ_a), 256'd2);
    check("fl_full.stall", 256'(stall_a), 256'd4);
    drive(1'b1, 11'h055, DATA_W'('hCC), 1'b0, 1'b1);
    step();
    check_main("flush", 1'b0, '0, DATA_W'('h21), 2'd0, 1'b1);
    check("flush.data_clr", 256'(data_b), 256'd0);
    check("flush.ctrl_clr", 256'(ctrl_b), 256'd0);
    check("flush.stall", 256'(stall_a), 256'd5);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    check_main("flush_after", 1'b0, '0, DATA_W'('h21), 2'd0, 1'b1);

    // Drain to empty
    drive(1'b1, 11'h155, DATA_W'('h5A), 1'b1, 1'b0);
    step();
    check_main("drain_load", 1'b1, 11'h155, DATA_W'('h5A), 2'd1, 1'b1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    check_main("drain", 1'b0, '0, DATA_W'('h5A), 2'd0, 1'b1);
    check("drain.data_clr", 256'(data_b), 256'd0);
    check("drain.ctrl_clr", 256'(ctrl_b), 256'd0);

    // Counter saturation on the 4-bit instance (starts at 5)
    drive(1'b1, 11'h001, DATA_W'('h99), 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (10) step();
    check("sat10.c", 256'(stall_c), 256'd15);
    check("sat10.a", 256'(stall_a), 256'd15);
    repeat (10) step();
    check("sat20.c", 256'(stall_c), 256'd15);
    check("sat20.a", 256'(stall_a), 256'd25);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    check("sat_flush.c", 256'(stall_c), 256'd15);
    check("sat_flush.a", 256'(stall_a), 256'd26);
    check("sat_flush.valid", 256'(valid_c), 256'd0);

    // Reset mid-stream while FULL
    drive(1'b1, 11'h0AA, DATA_W'('h31), 1'b0, 1'b0);
    step();
    drive(1'b1, 11'h0BB, DATA_W'('h32), 1'b0, 1'b0);
    step();
    check("mid_full.occ", 256'(occ_a), 256'd2);
    rst_n = 1'b0;
    #1;
    check_main("mid_reset", 1'b0, '0, '0, 2'd0, 1'b1);
    check("mid_reset.stall", 256'(stall_a), 256'd0);
    check("mid_reset.stall_c", 256'(stall_c), 256'd0);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 11'h066, DATA_W'('h77), 1'b0, 1'b0);
    step();
    check_main("post_reset", 1'b1, 11'h066, DATA_W'('h77), 2'd1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
